// File: rtl/sym_gemm_pkg.sv
// Shared types and helpers for the sym_gemm matrix engine.
// Holds the FSM encoding, packed-bus indexing and accumulator sizing.
package sym_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FIN,
        DONE
    } state_t;

    // Element [0][0] lives in the MSBs of a packed matrix bus.
    function automatic int elem_lsb(input int i, input int j, input int n, input int w);
        return (n * n - 1 - (i * n + j)) * w;
    endfunction

    function automatic int acc_width(input int n, input int w);
        return 3 * w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sym_gemm_mac.sv
// Shared multiply-accumulate datapath for sym_gemm.
// Accumulates one product per enabled cycle and scales/clamps the finished sum.
module sym_mac
    import sym_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int ACC_W = acc_width(N, W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] alpha_i,
    input  logic [W-1:0] beta_i,
    input  logic [W-1:0] c_i,
    input  logic         sat_en_i,
    output logic [W-1:0] elem_o,
    output logic         elem_ovf_o
);

    localparam logic [ACC_W-1:0] MAX_ELEM = {{(ACC_W - W){1'b0}}, {W{1'b1}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2*W-1:0]   prod;
    logic [2*W-1:0]   c_term;
    logic [ACC_W-1:0] scaled;
    logic [ACC_W-1:0] r;

    assign prod   = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    assign c_term = {{W{1'b0}}, beta_i} * {{W{1'b0}}, c_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W - 2*W){1'b0}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ACC_W leaves headroom for alpha*acc + beta*c, so r never wraps.
    assign scaled     = {{(ACC_W - W){1'b0}}, alpha_i} * acc_q;
    assign r          = scaled + {{(ACC_W - 2*W){1'b0}}, c_term};
    assign elem_ovf_o = (r > MAX_ELEM);
    assign elem_o     = (sat_en_i && elem_ovf_o) ? {W{1'b1}} : r[W-1:0];

endmodule

// File: rtl/sym_gemm.sv
// Sequential D = alpha*(A*B) + beta*C engine over N x N unsigned matrices.
// One shared MAC walks the result row-major; valid/ready handshakes on both sides.
module sym_gemm
    import sym_pkg::*;
#(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int ACC_W = acc_width(N, W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a_flat,
    input  logic [N*N*W-1:0] b_flat,
    input  logic [N*N*W-1:0] c_flat,
    input  logic [W-1:0]     alpha,
    input  logic [W-1:0]     beta,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] d_flat,
    output logic             ovf,
    output logic             busy
);

    localparam int BUS_W = N * N * W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state_q;
    logic [BUS_W-1:0] a_q, b_q, c_q, result_q;
    logic [W-1:0]     alpha_q, beta_q;
    logic             sat_q, ovf_acc_q, ovf_q;
    logic [IDX_W-1:0] i_q, j_q, k_q;

    logic         accept;
    logic [W-1:0] op_a, op_b, op_c, elem;
    logic         elem_ovf;

    assign accept = (state_q == IDLE) && in_valid;

    assign op_a = a_q[elem_lsb(int'(i_q), int'(k_q), N, W) +: W];
    assign op_b = b_q[elem_lsb(int'(k_q), int'(j_q), N, W) +: W];
    assign op_c = c_q[elem_lsb(int'(i_q), int'(j_q), N, W) +: W];

    sym_mac #(
        .N    (N),
        .W    (W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_i       (op_a),
        .b_i       (op_b),
        .clr_i     (accept || (state_q == FIN)),
        .en_i      (state_q == MAC),
        .alpha_i   (alpha_q),
        .beta_i    (beta_q),
        .c_i       (op_c),
        .sat_en_i  (sat_q),
        .elem_o    (elem),
        .elem_ovf_o(elem_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            result_q  <= '0;
            alpha_q   <= '0;
            beta_q    <= '0;
            sat_q     <= 1'b0;
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= a_flat;
                        b_q       <= b_flat;
                        c_q       <= c_flat;
                        alpha_q   <= alpha;
                        beta_q    <= beta;
                        sat_q     <= sat_en;
                        ovf_acc_q <= 1'b0;
                        i_q       <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        state_q   <= MAC;
                    end
                end
                MAC: begin
                    if (k_q == LAST) begin
                        state_q <= FIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                FIN: begin
                    result_q[elem_lsb(int'(i_q), int'(j_q), N, W) +: W] <= elem;
                    ovf_acc_q <= ovf_acc_q | elem_ovf;
                    k_q       <= '0;
                    state_q   <= MAC;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            // The output flag only moves when a whole result is published.
                            i_q     <= '0;
                            ovf_q   <= ovf_acc_q | elem_ovf;
                            state_q <= DONE;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign d_flat    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sym_gemm.sv
// Scoreboard bench for sym_gemm at N=2, W=8 with hand-computed directed vectors.
module tb_sym_gemm;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int BW = N * N * W;
    localparam int LATENCY = N * N * (N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] a_flat = '0;
    logic [BW-1:0] b_flat = '0;
    logic [BW-1:0] c_flat = '0;
    logic [W-1:0]  alpha = '0;
    logic [W-1:0]  beta = '0;
    logic          sat_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] d_flat;
    logic          ovf;
    logic          busy;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    typedef struct {
        logic [BW-1:0] d;
        logic          ovf;
        int            accCyc;
    } exp_t;

    exp_t sb[$];

    sym_gemm #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_flat   (a_flat),
        .b_flat   (b_flat),
        .c_flat   (c_flat),
        .alpha    (alpha),
        .beta     (beta),
        .sat_en   (sat_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d_flat   (d_flat),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Drives one operand set, waits (bounded) for acceptance and queues its expected result.
    task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                 input logic [BW-1:0] c, input logic [W-1:0] al,
                                 input logic [W-1:0] be, input logic sat,
                                 input logic [BW-1:0] expD, input logic expOvf,
                                 input logic hold, output int accCyc);
        exp_t e;
        @(negedge clk);
        a_flat   = a;
        b_flat   = b;
        c_flat   = c;
        alpha    = al;
        beta     = be;
        sat_en   = sat;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
        if (!in_ready) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            accCyc   = -1;
            return;
        end
        accCyc   = cyc + 1;
        e.d      = expD;
        e.ovf    = expOvf;
        e.accCyc = accCyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("drainTimeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    logic prevOv = 1'b0;
    logic prevHs = 1'b0;

    // Monitor: checks latency on each rising out_valid and contents on each output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevOv <= 1'b0;
            prevHs <= 1'b0;
        end else begin
            if (prevHs) checkOutput("validWidth", {31'd0, out_valid}, 32'd0);
            if (out_valid && !prevOv) begin
                if (sb.size() == 0) checkOutput("unexpectedResult", 32'd1, 32'd0);
                else checkOutput("latency", cyc - sb[0].accCyc, LATENCY);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                checkOutput("dFlat", d_flat, sb[0].d);
                checkOutput("ovf", {31'd0, ovf}, {31'd0, sb[0].ovf});
                void'(sb.pop_front());
            end
            prevHs <= out_valid && out_ready;
            prevOv <= out_valid;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c1, c2, extra;

        repeat (3) @(negedge clk);
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDFlat", d_flat, 32'd0);
        checkOutput("rstOvf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;

        // Plain product and scaled sum.
        applyStimulus(32'h01020304, 32'h05060708, 32'h0, 8'd1, 8'd0, 1'b0, 32'h13162B32, 1'b0, 1'b0, c1);
        waitDrain();
        applyStimulus(32'h01020304, 32'h05060708, 32'h01010101, 8'd2, 8'd3, 1'b0, 32'h292F5967, 1'b0, 1'b0, c1);
        waitDrain();

        // Overflow in both output modes.
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 8'd1, 8'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, c1);
        waitDrain();
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 8'd1, 8'd0, 1'b0, 32'h02020202, 1'b1, 1'b0, c1);
        waitDrain();

        // Exactly 255 is not an overflow; 256 saturates and flags.
        applyStimulus(32'hFF000000, 32'h01000001, 32'h0, 8'd1, 8'd0, 1'b1, 32'hFF000000, 1'b0, 1'b0, c1);
        waitDrain();
        applyStimulus(32'hFF000000, 32'h01000001, 32'h01000000, 8'd1, 8'd1, 1'b1, 32'hFF000000, 1'b1, 1'b0, c1);
        waitDrain();
        applyStimulus(32'hFF000000, 32'h01000001, 32'h01000000, 8'd1, 8'd1, 1'b0, 32'h00000000, 1'b1, 1'b0, c1);
        waitDrain();

        // alpha=0 passes beta*C straight through.
        applyStimulus(32'h09090909, 32'h07070707, 32'h0A0B0C0D, 8'd0, 8'd1, 1'b0, 32'h0A0B0C0D, 1'b0, 1'b0, c1);
        waitDrain();

        // Backpressure with a stray in_valid pulse while the result is held.
        out_ready = 1'b0;
        applyStimulus(32'h01020304, 32'h05060708, 32'h01010101, 8'd2, 8'd3, 1'b0, 32'h292F5967, 1'b0, 1'b0, c1);
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        checkOutput("bpValidSeen", {31'd0, out_valid}, 32'd1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            in_valid = (t == 1);
            a_flat   = 32'hFFFFFFFF;
            checkOutput("bpDFlat", d_flat, 32'h292F5967);
            checkOutput("bpOvf", {31'd0, ovf}, 32'd0);
            checkOutput("bpInReady", {31'd0, in_ready}, 32'd0);
            checkOutput("bpBusy", {31'd0, busy}, 32'd1);
            checkOutput("bpOutValid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        extra = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checkOutput("noSecondResult", extra, 32'd0);

        // Reset in the middle of a MAC sequence.
        applyStimulus(32'h01020304, 32'h05060708, 32'h0, 8'd1, 8'd0, 1'b0, 32'h13162B32, 1'b0, 1'b0, c1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("midRstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("midRstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstDFlat", d_flat, 32'd0);
        checkOutput("midRstOvf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h01020304, 32'h05060708, 32'h01010101, 8'd2, 8'd3, 1'b0, 32'h292F5967, 1'b0, 1'b0, c1);
        waitDrain();

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        applyStimulus(32'h01020304, 32'h05060708, 32'h0, 8'd1, 8'd0, 1'b0, 32'h13162B32, 1'b0, 1'b1, c1);
        applyStimulus(32'h01020304, 32'h05060708, 32'h01010101, 8'd2, 8'd3, 1'b0, 32'h292F5967, 1'b0, 1'b0, c2);
        checkOutput("b2bPeriod", c2 - c1, N * N * (N + 1) + 2);
        waitDrain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sym_gemm.md
# sym_gemm

Parametrised sequential matrix engine computing D = alpha·(A·B) + beta·C over N×N unsigned matrices of W-bit elements. Operands arrive packed in flat buses under a valid/ready handshake; results are held under a second valid/ready handshake. A single shared MAC unit iterates over elements, trading latency for area. It is the general successor of the fixed 2×2 packed-matrix compute block and adds:

- configurable dimension and element width
- a true C addend
- wrap/saturate output modes
- an overflow flag
- flow control

## Interface

**Parameters**
- N, 2, matrix dimension (N ≥ 2)
- W, 8, element width in bits
- ACC_W, 3*W+$clog2(N)+1, internal accumulator width (derived, do not override)

**Ports**
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand set valid
- in_ready  out  1  engine can accept operands
- a_flat  in  N*N*W  matrix A, packed
- b_flat  in  N*N*W  matrix B, packed
- c_flat  in  N*N*W  matrix C, packed
- alpha  in  W  scale for A·B, unsigned
- beta  in  W  scale for C, unsigned
- sat_en  in  1  1 = saturate results, 0 = wrap results
- out_valid  out  1  d_flat/ovf valid
- out_ready  in  1  consumer accepts result
- d_flat  out  N*N*W  result matrix, packed
- ovf  out  1  at least one element exceeded 2^W−1
- busy  out  1  high in every state except IDLE

Packing: element [i][j] occupies bits ((N*N−1−(i*N+j))*W) +: W, so [0][0] sits in the MSBs.

## Operation

**FSM states:** IDLE, MAC, FIN, DONE.

- **IDLE:** in_ready=1. On in_valid&&in_ready, capture a/b/c/alpha/beta/sat_en into internal registers, clear ovf_acc, set i=j=k=0, clear acc, go to MAC. Inputs are ignored after capture.
- **MAC:** acc += A[i][k]*B[k][j], one product per cycle. At k=N−1 go to FIN; otherwise k++.
- **FIN:** one cycle. Compute r = alpha*acc + beta*C[i][j] in ACC_W bits (no loss).
  - Element value: sat_en ? min(r, 2^W−1) : r[W−1:0], written into result element [i][j].
  - ovf_acc |= (r > 2^W−1).
  - Then clear acc and k. Advance j, then i (row-major).
  - After element [N−1][N−1], go to DONE; otherwise go to MAC.
- **DONE:** out_valid=1; d_flat and ovf held stable. On out_ready, go to IDLE.
- in_ready=0 in MAC, FIN and DONE. in_valid in those states is ignored, not queued.

## Timing

- Reset (async assert): state=IDLE, in_ready=1, out_valid=0, d_flat=0, ovf=0, busy=0. All counters and acc cleared.
- Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- Latency: out_valid rises N*N*(N+1) clock edges after the accepting edge (12 for N=2).
- Result register updates only in FIN. d_flat reflects the completed result only while out_valid=1. Between operations d_flat holds the previous result.
- out_valid may stay high indefinitely. d_flat and ovf do not change until the out_valid&&out_ready edge.
- in_ready rises the cycle after the output handshake. Minimum operation period is N*N*(N+1)+2 cycles (14 for N=2).
- out_ready high on entry to DONE: out_valid is high exactly one cycle.
- All arithmetic is unsigned. alpha=0 and/or beta=0 are legal.

## Structure

- **Package sym_pkg:**
  - state enum (IDLE, MAC, FIN, DONE)
  - function elem_lsb(i, j, N, W) for packed-bus indexing
  - ACC_W derivation as a function of N and W
- **Sub-module sym_mac:**
  - combinational/registered multiply-accumulate plus final scale-add-clamp
  - ports: operand pair, clear, enable, alpha, beta, c, sat_en → acc, elem, elem_ovf
- The top level holds the FSM, index counters, operand/result registers and both handshakes.

## Test plan

All scenarios use N=2, W=8.

1. **Plain product.** a=32'h01020304, b=32'h05060708, c=0, alpha=1, beta=0, sat_en=0 → d_flat=32'h13162B32, ovf=0, out_valid 12 edges after accept.
2. **Scaled sum.** Same A/B, c=32'h01010101, alpha=2, beta=3 → d_flat=32'h292F5967, ovf=0.
3. **Overflow.** a=b=32'hFFFFFFFF, alpha=1, beta=0:
   - sat_en=1 → d_flat=32'hFFFFFFFF, ovf=1
   - sat_en=0 → d_flat=32'h02020202, ovf=1
4. **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid → d_flat/ovf stable, in_ready=0, busy=1. A second in_valid pulse during this window produces no second result.
5. **Reset mid-MAC.** Assert rst_n=0 at cycle 5 of scenario 1 → outputs immediately at reset values. After release, rerunning scenario 2 gives 32'h292F5967.
6. **Back-to-back.** in_valid and out_ready held high with scenarios 1 and 2 queued → results appear in order, 14 cycles apart. out_valid is one cycle wide each time.
